// File: rtl/xorshift_arbiter.sv
// xorshift_arbiter: round-robin arbiter and seed sequencer sharing one
// xorshift+ core between NREQ requesters.
// Optional feature macro: XORSHIFT_ARB_STATS_EN (adds draw/reseed counters).
module xorshift_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter logic [63:0] DEFAULT_SEED_A = 64'h1234,
  parameter logic [63:0] DEFAULT_SEED_B = 64'h1234
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] valid_o,
  output logic [63:0]     rand_o,
  input  logic            reseed_i,
  input  logic [63:0]     seed_a_i,
  input  logic [63:0]     seed_b_i,
  output logic            busy_o,
  output logic            core_load_o,
  output logic [63:0]     core_seed_a_o,
  output logic [63:0]     core_seed_b_o,
  output logic            core_gen_o,
  input  logic [63:0]     core_rand_i
`ifdef XORSHIFT_ARB_STATS_EN
  ,
  output logic [31:0]     draw_count_o,
  output logic [15:0]     reseed_count_o
`endif
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_GEN,
    S_CAPT,
    S_DLV,
    S_RESEED
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic              pend_q, pend_d;
  logic [63:0]       cap_a_q, cap_a_d;
  logic [63:0]       cap_b_q, cap_b_d;
  logic [63:0]       seed_a_q, seed_a_d;
  logic [63:0]       seed_b_q, seed_b_d;
  logic              load_q, load_d;
  logic              gen_q, gen_d;
  logic [NREQ-1:0]   valid_q, valid_d;
  logic [63:0]       rand_q, rand_d;
  logic              busy_q, busy_d;

  logic              arb_found;
  logic [IDXW-1:0]   arb_idx;
  logic [IDXW-1:0]   arb_next;

`ifdef XORSHIFT_ARB_STATS_EN
  logic [31:0]       draw_cnt_q, draw_cnt_d;
  logic [15:0]       reseed_cnt_q, reseed_cnt_d;
`endif

  // Round-robin search: first set request at or above rr_q, wrapping at NREQ.
  always_comb begin : arb
    int unsigned cand;
    int unsigned nxt;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!arb_found && req_i[IDXW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IDXW'(cand);
      end
    end
    nxt = 32'(arb_idx) + 1;
    if (nxt >= NREQ) nxt = 0;
    arb_next = IDXW'(nxt);
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    pend_d   = pend_q;
    cap_a_d  = cap_a_q;
    cap_b_d  = cap_b_q;
    seed_a_d = seed_a_q;
    seed_b_d = seed_b_q;
    rand_d   = rand_q;
    valid_d  = '0;

    unique case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (pend_q) begin
          state_d  = S_RESEED;
          seed_a_d = cap_a_q;
          seed_b_d = cap_b_q;
        end else if (arb_found) begin
          grant_d = arb_idx;
          rr_d    = arb_next;
          state_d = S_GEN;
        end
      end
      S_GEN:  state_d = S_CAPT;
      S_CAPT: begin
        rand_d  = core_rand_i;
        valid_d = NREQ'(1) << grant_q;
        state_d = S_DLV;
      end
      S_DLV:  state_d = S_IDLE;
      S_RESEED: begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // A reseed command arriving during RESEED re-arms the flag so the newer
    // seeds get their own load pulse rather than being silently dropped.
    if (reseed_i) begin
      pend_d = 1'b1;
      if (seed_a_i == '0 && seed_b_i == '0) begin
        cap_a_d = DEFAULT_SEED_A;
        cap_b_d = DEFAULT_SEED_B;
      end else begin
        cap_a_d = seed_a_i;
        cap_b_d = seed_b_i;
      end
    end

    load_d = (state_d == S_RESEED);
    gen_d  = (state_d == S_GEN);
    busy_d = (state_d != S_IDLE);
  end

`ifdef XORSHIFT_ARB_STATS_EN
  // Draw counter wraps; reseed counter saturates.
  always_comb begin
    draw_cnt_d   = draw_cnt_q;
    reseed_cnt_d = reseed_cnt_q;
    if (state_q == S_DLV) draw_cnt_d = draw_cnt_q + 32'd1;
    if (state_d == S_RESEED && state_q != S_RESEED && reseed_cnt_q != '1)
      reseed_cnt_d = reseed_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      draw_cnt_q   <= '0;
      reseed_cnt_q <= '0;
    end else begin
      draw_cnt_q   <= draw_cnt_d;
      reseed_cnt_q <= reseed_cnt_d;
    end
  end

  assign draw_count_o   = draw_cnt_q;
  assign reseed_count_o = reseed_cnt_q;
`endif

  // State and registered outputs; reset enters INIT with the load pulse armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      grant_q  <= '0;
      rr_q     <= '0;
      pend_q   <= 1'b0;
      cap_a_q  <= DEFAULT_SEED_A;
      cap_b_q  <= DEFAULT_SEED_B;
      seed_a_q <= DEFAULT_SEED_A;
      seed_b_q <= DEFAULT_SEED_B;
      load_q   <= 1'b1;
      gen_q    <= 1'b0;
      valid_q  <= '0;
      rand_q   <= '0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      pend_q   <= pend_d;
      cap_a_q  <= cap_a_d;
      cap_b_q  <= cap_b_d;
      seed_a_q <= seed_a_d;
      seed_b_q <= seed_b_d;
      load_q   <= load_d;
      gen_q    <= gen_d;
      valid_q  <= valid_d;
      rand_q   <= rand_d;
      busy_q   <= busy_d;
    end
  end

  assign valid_o       = valid_q;
  assign rand_o        = rand_q;
  assign busy_o        = busy_q;
  assign core_load_o   = load_q;
  assign core_seed_a_o = seed_a_q;
  assign core_seed_b_o = seed_b_q;
  assign core_gen_o    = gen_q;

endmodule

// File: tb/tb_xorshift_arbiter.sv
// Directed bench for xorshift_arbiter with a behavioural xorshift+ core.
module tb_xorshift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_i;
  logic [3:0]  valid_o;
  logic [63:0] rand_o;
  logic        reseed_i;
  logic [63:0] seed_a_i, seed_b_i;
  logic        busy_o, core_load_o, core_gen_o;
  logic [63:0] core_seed_a_o, core_seed_b_o, core_rand_i;
`ifdef XORSHIFT_ARB_STATS_EN
  logic [31:0] draw_count_o;
  logic [15:0] reseed_count_o;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] DEF = 64'h1234;

  xorshift_arbiter #(
    .NREQ(4),
    .DEFAULT_SEED_A(64'h1234),
    .DEFAULT_SEED_B(64'h1234)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req_i),
    .valid_o(valid_o),
    .rand_o(rand_o),
    .reseed_i(reseed_i),
    .seed_a_i(seed_a_i),
    .seed_b_i(seed_b_i),
    .busy_o(busy_o),
    .core_load_o(core_load_o),
    .core_seed_a_o(core_seed_a_o),
    .core_seed_b_o(core_seed_b_o),
    .core_gen_o(core_gen_o),
    .core_rand_i(core_rand_i)
`ifdef XORSHIFT_ARB_STATS_EN
    ,
    .draw_count_o(draw_count_o),
    .reseed_count_o(reseed_count_o)
`endif
  );

  always #5 clk = ~clk;

  // xorshift128+ step: returns {new_s0, new_s1, output}
  function automatic logic [191:0] xs_step(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y, nb;
    x  = a;
    y  = b;
    x  = x ^ (x << 23);
    nb = x ^ y ^ (x >> 17) ^ (y >> 26);
    return {y, nb, nb + y};
  endfunction

  // Behavioural core: load on core_load_o, advance on core_gen_o
  logic [63:0] cs_a, cs_b;
  always @(posedge clk) begin
    if (core_load_o === 1'b1) begin
      cs_a        <= core_seed_a_o;
      cs_b        <= core_seed_b_o;
      core_rand_i <= '0;
    end else if (core_gen_o === 1'b1) begin
      {cs_a, cs_b, core_rand_i} <= xs_step(cs_a, cs_b);
    end
  end

  // Independent reference state, advanced once per expected draw
  logic [63:0] ref_a, ref_b, ref_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue req in an IDLE cycle and verify one full draw.
  task automatic do_draw(input logic [3:0] req, input int unsigned g, input string name);
    int n;
    int gens;
    n    = 0;
    gens = 0;
    req_i = req;
    do begin
      tick();
      n++;
      if (core_gen_o === 1'b1) gens++;
    end while (valid_o === 4'b0000 && n < 8);
    {ref_a, ref_b, ref_out} = xs_step(ref_a, ref_b);
    check({name, "_latency"}, 64'(n), 64'd3);
    check({name, "_gen_pulses"}, 64'(gens), 64'd1);
    check({name, "_valid"}, 64'(valid_o), 64'(4'b0001 << g));
    check({name, "_rand"}, rand_o, ref_out);
    tick();
    req_i = '0;
    check({name, "_valid_clr"}, 64'(valid_o), 64'd0);
    check({name, "_rand_hold"}, rand_o, ref_out);
    check({name, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  typedef struct {
    logic [3:0]  req;
    int unsigned grant;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int loads;
    int vals;

    // Request pattern and expected grant, assuming rr pointer 0 after reset
    tbl[0]  = '{4'b0001, 0};  // rr -> 1
    tbl[1]  = '{4'b1111, 1};
    tbl[2]  = '{4'b1111, 2};
    tbl[3]  = '{4'b1111, 3};
    tbl[4]  = '{4'b1111, 0};  // wrap
    tbl[5]  = '{4'b1111, 1};  // rr -> 2
    tbl[6]  = '{4'b0101, 2};  // rr -> 3
    tbl[7]  = '{4'b0101, 0};  // search 3 then wraps to 0
    tbl[8]  = '{4'b1000, 3};  // rr -> 0
    tbl[9]  = '{4'b0110, 1};  // rr -> 2
    tbl[10] = '{4'b1001, 3};  // rr -> 0

    rst = 1'b1; req_i = '0; reseed_i = 1'b0; seed_a_i = '0; seed_b_i = '0;

    // Reset then idle
    tick();
    check("rst_load", 64'(core_load_o), 64'd1);
    check("rst_seed_a", core_seed_a_o, DEF);
    check("rst_seed_b", core_seed_b_o, DEF);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_rand", rand_o, 64'd0);
    check("rst_gen", 64'(core_gen_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd1);
`ifdef XORSHIFT_ARB_STATS_EN
    check("rst_draw_count", 64'(draw_count_o), 64'd0);
    check("rst_reseed_count", 64'(reseed_count_o), 64'd0);
`endif
    rst = 1'b0;
    tick();
    check("init_load_one_cycle", 64'(core_load_o), 64'd0);
    check("init_idle_busy", 64'(busy_o), 64'd0);
    check("init_idle_valid", 64'(valid_o), 64'd0);
    ref_a = DEF; ref_b = DEF;

    // Table-driven draws (single draw, round robin, wrap cases)
    for (int i = 0; i < 11; i++)
      do_draw(tbl[i].req, tbl[i].grant, $sformatf("tbl%0d", i));

    // Reseed during GEN, overwritten during CAPT; draw completes first
    req_i = 4'b0001;
    tick();
    check("md_gen", 64'(core_gen_o), 64'd1);
    req_i = '0;
    reseed_i = 1'b1; seed_a_i = 64'h1111; seed_b_i = 64'h2222;
    tick();
    seed_a_i = 64'hDEAD; seed_b_i = 64'hBEEF;
    tick();
    reseed_i = 1'b0;
    {ref_a, ref_b, ref_out} = xs_step(ref_a, ref_b);
    check("md_valid", 64'(valid_o), 64'd1);
    check("md_rand", rand_o, ref_out);
    tick();
    check("md_pend_idle_load", 64'(core_load_o), 64'd0);
    req_i = 4'b0010;  // pending reseed must win over this request
    tick();
    check("md_reseed_load", 64'(core_load_o), 64'd1);
    check("md_reseed_gen", 64'(core_gen_o), 64'd0);
    check("md_reseed_seed_a", core_seed_a_o, 64'hDEAD);
    check("md_reseed_seed_b", core_seed_b_o, 64'hBEEF);
    check("md_reseed_busy", 64'(busy_o), 64'd1);
    req_i = '0;
    tick();
    check("md_load_one_cycle", 64'(core_load_o), 64'd0);
    ref_a = 64'hDEAD; ref_b = 64'hBEEF;
    do_draw(4'b0010, 1, "dead_beef_1");   // rr 1 -> 2
    do_draw(4'b0011, 0, "dead_beef_2");   // search 2,3,0 -> rr 1

    // Zero seed substitution
    reseed_i = 1'b1; seed_a_i = '0; seed_b_i = '0;
    tick();
    reseed_i = 1'b0;
    tick();
    check("zs_load", 64'(core_load_o), 64'd1);
    check("zs_seed_a", core_seed_a_o, DEF);
    check("zs_seed_b", core_seed_b_o, DEF);
    tick();
    ref_a = DEF; ref_b = DEF;
    do_draw(4'b1100, 2, "zero_seed_draw");  // rr -> 3
`ifdef XORSHIFT_ARB_STATS_EN
    check("stat_draws", 64'(draw_count_o), 64'd15);
    check("stat_reseeds", 64'(reseed_count_o), 64'd2);
`endif

    // rst during CAPT abandons the draw
    req_i = 4'b0100;
    tick();
    req_i = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rc_load", 64'(core_load_o), 64'd1);
    check("rc_valid", 64'(valid_o), 64'd0);
    check("rc_rand", rand_o, 64'd0);
    check("rc_seed_a", core_seed_a_o, DEF);
`ifdef XORSHIFT_ARB_STATS_EN
    check("rc_draw_count", 64'(draw_count_o), 64'd0);
    check("rc_reseed_count", 64'(reseed_count_o), 64'd0);
`endif
    loads = 0; vals = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (core_load_o === 1'b1) loads++;
      if (valid_o !== 4'b0000) vals++;
    end
    check("rc_no_valid", 64'(vals), 64'd0);
    check("rc_single_load", 64'(loads), 64'd0);
    ref_a = DEF; ref_b = DEF;
    do_draw(4'b1001, 0, "after_rst_rr");  // rr reset to 0 -> grant 0

    // rst and reseed together: reseed is lost
    rst = 1'b1; reseed_i = 1'b1; seed_a_i = 64'hAAAA; seed_b_i = 64'hBBBB;
    tick();
    rst = 1'b0; reseed_i = 1'b0;
    loads = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_load_o === 1'b1) loads++;
    end
    check("rr_reseed_lost", 64'(loads), 64'd0);
    ref_a = DEF; ref_b = DEF;
    do_draw(4'b1001, 0, "rst_beats_reseed");
`ifdef XORSHIFT_ARB_STATS_EN
    check("stat_final_draws", 64'(draw_count_o), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xorshift_arbiter.md
Name: xorshift_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one xorshiftPlus core (64-bit xorshift+ generator) between NREQ requesters.
- Issues one-cycle gen pulses to the core and routes each fresh 64-bit result to exactly one requester with a valid pulse.
- Sequences core (re)seeding: at power-up and on request. Substitutes a default seed when the requested seed is all-zero.
- Sits between the core's clk/rst/seed/gen/randOut pins and the consumers.

Parameters:
- NREQ, 4: number of requesters (2..16).
- DEFAULT_SEED_A, 64'h1234: seed 0 loaded after reset and on zero-seed substitution.
- DEFAULT_SEED_B, 64'h1234: seed 1 loaded after reset and on zero-seed substitution.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  NREQ  per-requester draw request (level).
- valid_o  out  NREQ  one-hot, one-cycle pulse; rand_o is valid for that requester.
- rand_o  out  64  shared result bus.
- reseed_i  in  1  one-cycle reseed command.
- seed_a_i  in  64  new seed 0, sampled when reseed_i=1.
- seed_b_i  in  64  new seed 1, sampled when reseed_i=1.
- busy_o  out  1  high whenever state != IDLE.
- core_load_o  out  1  drives the core's rst pin; loads core_seed_a/b_o.
- core_seed_a_o  out  64  seed 0 to the core.
- core_seed_b_o  out  64  seed 1 to the core.
- core_gen_o  out  1  drives the core's gen pin.
- core_rand_i  in  64  core randOut.

Behaviour:
- Core contract: core_load_o=1 at edge e loads the seeds; core_gen_o=1 at edge e makes core_rand_i show the next value after e.
- Reset (rst=1 at an edge):
  - state=INIT; valid_o=0; rand_o=0; core_gen_o=0.
  - core_seed_a/b_o=DEFAULT_SEED_A/B; rr_ptr=0; pending reseed flag cleared.
- INIT: core_load_o=1 for one cycle, then go to IDLE. core_load_o is 0 in every other state.
- IDLE, priority order:
  - Pending reseed flag set -> RESEED.
  - Else, any req_i bit high -> grant the first set bit searching from rr_ptr upward with wrap, latch it as g, set rr_ptr=(g+1) mod NREQ, go to GEN.
  - Else stay in IDLE.
- GEN: core_gen_o=1 for exactly one cycle, then go to CAPT.
- CAPT: rand_o<=core_rand_i; valid_o<=onehot(g); go to DLV.
- DLV: valid_o[g]=1 and rand_o holds the drawn value for exactly one cycle. At the edge leaving DLV: valid_o<=0, rand_o holds its value, go to IDLE.
- Draw latency: req sampled at the edge leaving IDLE -> valid_o high 3 cycles later. Sustained throughput is one draw per 4 cycles.
- Requester rule: deassert req_i at the edge ending its DLV cycle. req_i still high in the following IDLE cycle counts as a new request.
- Reseed:
  - reseed_i=1 in any state sets the pending flag and captures both seeds.
  - If seed_a_i and seed_b_i are both 0, capture DEFAULT_SEED_A/B instead (an all-zero xorshift state locks up).
  - A second reseed_i before service overwrites the captured seeds.
  - In-flight draws (GEN/CAPT/DLV) always complete first.
  - RESEED state: drive core_seed_a/b_o from the capture, core_load_o=1 for one cycle, clear the flag, go to IDLE.
- Requests are never dropped. Unserved requesters keep req_i high and win within NREQ grants.
- rst mid-draw: the draw is abandoned, no valid_o is issued, and the core is reloaded with the default seeds via INIT.
- rst has priority over reseed_i in the same cycle; the reseed is lost.

Optional Feature:
- Macro: XORSHIFT_ARB_STATS_EN.
- Defined: adds output port draw_count_o [31:0] (reset 0).
  - Increments by 1 at every edge leaving DLV; wraps 32'hFFFFFFFF -> 0.
  - Also adds reseed_count_o [15:0] (reset 0), incremented on each RESEED entry; saturates at 16'hFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then idle: rst 1 cycle -> core_load_o=1 for exactly 1 cycle with seeds 64'h1234/64'h1234; valid_o=0, busy_o=0 afterwards.
- Single draw: req_i=4'b0001 for 1 cycle after IDLE -> core_gen_o pulses 1 cycle; valid_o=4'b0001 exactly 3 cycles after the sampling edge; rand_o equals the core output following that gen.
- Round robin: req_i=4'b1111 held -> grant order 0,1,2,3,0; each valid one-hot; a new valid every 4 cycles.
- Reseed mid-draw: reseed_i with seeds 64'hDEAD/64'hBEEF during GEN -> draw completes; next state RESEED loads DEAD/BEEF; two consecutive draws then match the reference model seeded with DEAD/BEEF.
- Zero seed: reseed_i with 0/0 -> core_seed_a/b_o=64'h1234/64'h1234 during the load pulse.
- rst during CAPT -> no valid_o pulse; INIT reload occurs; with XORSHIFT_ARB_STATS_EN, draw_count_o=0.
